// File: rtl/line_bus_master.sv
// line_bus_master: moves whole cache lines over a single-word memory port.
// A line request is split into WORDS ascending word accesses. Each word waits
// for BusValid. A run of MAX_WAIT idle edges aborts the line with RespErr.
module line_bus_master #(
  parameter int WORDS    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [31:0]          ReqAddr,
  input  logic [WORDS*32-1:0]  ReqWData,
  output logic                 RespValid,
  output logic                 RespErr,
  output logic [WORDS*32-1:0]  RespRData,
  output logic [31:0]          BusA,
  output logic [31:0]          BusWD,
  output logic                 BusWE,
  output logic                 BusRE,
  output logic                 BusHSEL,
  input  logic [31:0]          BusRD,
  input  logic                 BusValid
);

  localparam int CW  = $clog2(WORDS);
  localparam int OFF = CW + 2;
  localparam int WW  = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] BASE_MASK = ~((32'd1 << OFF) - 32'd1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                  state_reg;
  logic [CW-1:0]               counter_reg;
  logic [WW-1:0]               wait_reg;
  logic [31:0]                 base_reg;
  logic                        err_reg;
  logic [WORDS-1:0][31:0]      wdata_reg;
  logic [WORDS-1:0][31:0]      rbuf_reg;
  logic [WORDS-1:0][31:0]      rbuf_next;
  logic [WORDS-1:0][31:0]      resp_rdata_reg;

  logic busy;
  logic last_word;
  logic timeout;
  logic capture;
  logic finish;

  assign busy      = (state_reg == S_READ) || (state_reg == S_WRITE);
  assign last_word = (counter_reg == CW'(WORDS - 1));
  assign timeout   = !BusValid && (wait_reg == WW'(MAX_WAIT - 1));
  assign capture   = (state_reg == S_READ) && BusValid;
  assign finish    = busy && ((BusValid && last_word) || timeout);

  // Read buffer: only the word currently on the bus can be overwritten.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_rbuf
      assign rbuf_next[gi] = (capture && (counter_reg == CW'(gi))) ? BusRD : rbuf_reg[gi];
    end
  endgenerate

  // Word address never carries out of the line: base has its offset bits clear.
  assign BusA      = base_reg | {{(30 - CW){1'b0}}, counter_reg, 2'b00};
  assign BusWD     = (state_reg == S_WRITE) ? wdata_reg[counter_reg] : 32'd0;
  assign BusWE     = (state_reg == S_WRITE);
  assign BusRE     = (state_reg == S_READ);
  assign BusHSEL   = busy;
  assign ReqReady  = (state_reg == S_IDLE);
  assign RespValid = (state_reg == S_DONE);
  assign RespErr   = (state_reg == S_DONE) && err_reg;
  assign RespRData = resp_rdata_reg;

  // Transfer sequencing, wait counting and line capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      counter_reg    <= '0;
      wait_reg       <= '0;
      base_reg       <= '0;
      err_reg        <= 1'b0;
      wdata_reg      <= '0;
      rbuf_reg       <= '0;
      resp_rdata_reg <= '0;
    end else begin
      rbuf_reg <= rbuf_next;
      case (state_reg)
        S_IDLE: begin
          if (ReqValid) begin
            base_reg    <= ReqAddr & BASE_MASK;
            counter_reg <= '0;
            wait_reg    <= '0;
            if (ReqWrite) begin
              wdata_reg <= ReqWData;
              state_reg <= S_WRITE;
            end else begin
              state_reg <= S_READ;
            end
          end
        end
        S_READ, S_WRITE: begin
          if (BusValid) begin
            wait_reg <= '0;
            if (last_word) begin
              state_reg <= S_DONE;
              err_reg   <= 1'b0;
            end else begin
              counter_reg <= counter_reg + 1'b1;
            end
          end else if (timeout) begin
            state_reg <= S_DONE;
            err_reg   <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
          // Publish the line (including any partial timeout result) on completion.
          if ((state_reg == S_READ) && finish) begin
            resp_rdata_reg <= rbuf_next;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_bus_master.md
Name: line_bus_master

Overview:
- Bus initiator that moves whole cache lines between a line-granular requester (cache fill/writeback logic) and the word-wide data memory port.
- Splits each line request into WORDS sequential single-word accesses on the memory's a/wd/we/re/HSEL interface and waits on the memory's Valid for each word.
- For reads, assembles the returned words into a line buffer. Reports completion or timeout back to the requester.

Parameters:
- WORDS, 4, words per line; power of two, 2..16.
- MAX_WAIT, 15, consecutive cycles with BusValid low before the transfer aborts; 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ReqValid  input  1  requester presents a line request
- ReqReady  output  1  block accepts a request this cycle
- ReqWrite  input  1  1 = line write, 0 = line read
- ReqAddr  input  32  line address; low log2(WORDS)+2 bits ignored
- ReqWData  input  WORDS*32  write line; word i at bits [32i+31:32i]
- RespValid  output  1  one-cycle completion pulse
- RespErr  output  1  valid with RespValid; 1 = timeout abort
- RespRData  output  WORDS*32  read line; same word packing as ReqWData
- BusA  output  32  word byte address to memory
- BusWD  output  32  write data to memory
- BusWE  output  1  write strobe
- BusRE  output  1  read strobe
- BusHSEL  output  1  memory select
- BusRD  input  32  read data from memory, combinational on BusA
- BusValid  input  1  memory completes the current word this cycle

Behaviour:
- Reset values: state IDLE, counter 0, wait count 0. ReqReady=1; RespValid, RespErr, BusWE, BusRE and BusHSEL are 0; BusA=0, BusWD=0, RespRData=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - ReqReady=1; all bus strobes 0.
  - On ReqValid & ReqReady: latch base = ReqAddr with low log2(WORDS)+2 bits cleared; latch ReqWData if ReqWrite.
  - Clear counter and wait count; go to WRITE if ReqWrite, else READ.
- BusA = base | (counter<<2). No carry into bits above the line offset, and no wrap past the line.
- READ:
  - BusRE=1, BusHSEL=1, BusWE=0.
  - On each clk edge with BusValid=1: capture BusRD into buffer word[counter] and clear wait count.
  - If counter==WORDS-1, go to DONE with RespErr=0; otherwise increment counter.
- WRITE:
  - BusWE=1, BusHSEL=1, BusRE=0, BusWD=latched word[counter].
  - Word advance and completion rules are identical to READ. Memory commits the word on the same edge.
- Wait/timeout:
  - In READ/WRITE, each edge with BusValid=0 increments wait count.
  - When wait count reaches MAX_WAIT: go to DONE with RespErr=1 and drop strobes on that edge.
  - Words already captured or written stay as-is.
- DONE:
  - RespValid=1 for exactly one cycle; ReqReady=0; bus strobes 0; next state IDLE.
- RespRData holds the read buffer from DONE until the next read completes. Write requests leave it unchanged.
- Word order is always ascending, word 0 first.
- Latency: with BusValid constantly high, accept at edge N, words at edges N+1..N+WORDS, RespValid high in cycle after edge N+WORDS. Total WORDS+1 cycles from accept to RespValid.
- ReqValid while not IDLE: ignored (ReqReady=0); the request is not queued.
- Reset in any state: next edge forces IDLE and reset values. No RespValid is issued for the aborted transfer, and strobes fall in the cycle after the reset edge.
- Each word occupies exactly one BusValid-high edge. BusWE and BusRE are never both 1.

Test Plan:
- Read, WORDS=4, BusValid tied 1, memory words 0x11,0x22,0x33,0x44 at 0x100..0x10C, ReqAddr=0x10B → BusA 0x100,0x104,0x108,0x10C on consecutive cycles; RespValid 5 cycles after accept; RespRData={0x44,0x33,0x22,0x11}; RespErr=0.
- Write, ReqAddr=0x200, ReqWData={0xD,0xC,0xB,0xA} → BusWE high 4 cycles, BusWD 0xA,0xB,0xC,0xD at 0x200..0x20C; memory readback matches; RespRData unchanged.
- Wait states: BusValid low 3 cycles before word 1 → BusA holds 0x104 for 4 cycles; final data correct; RespValid 8 cycles after accept.
- Timeout: MAX_WAIT=15, BusValid forced 0 after word 0 → after 15 idle edges RespValid=1, RespErr=1, strobes 0; next request is accepted normally.
- Reset during READ at word 2 → next cycle ReqReady=1, strobes 0, no RespValid pulse; a following read completes correctly.
- ReqValid held high through a transfer → only one transfer occurs per accept. A second request is accepted in the IDLE cycle after RespValid.
